// File: rtl/ram_test_cmd_scheduler.sv
// Round-robin scheduler merging the write and read command streams into one dispatcher port.
// Reads are held back until enough write-done credits have accumulated.
module ram_test_cmd_scheduler #(
  parameter int WR_DATA_WIDTH  = 96,
  parameter int RD_DATA_WIDTH  = 97,
  parameter int TRAIL_DISTANCE = 1,
  parameter int CREDIT_WIDTH   = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     drain,
  input  logic                     wr_done,
  input  logic [WR_DATA_WIDTH-1:0] wr_cmd_data,
  input  logic                     wr_cmd_valid,
  output logic                     wr_cmd_ready,
  input  logic [RD_DATA_WIDTH-1:0] rd_cmd_data,
  input  logic                     rd_cmd_valid,
  output logic                     rd_cmd_ready,
  output logic [RD_DATA_WIDTH-1:0] out_cmd_data,
  output logic                     out_cmd_is_read,
  output logic                     out_cmd_valid,
  input  logic                     out_cmd_ready,
  output logic [CREDIT_WIDTH-1:0]  credit_count,
  output logic                     credit_overflow
);

  localparam logic [CREDIT_WIDTH-1:0] CREDIT_MAX   = {CREDIT_WIDTH{1'b1}};
  localparam logic [CREDIT_WIDTH-1:0] CREDIT_ONE   = CREDIT_WIDTH'(1);
  localparam logic [CREDIT_WIDTH-1:0] TRAIL_THRESH = CREDIT_WIDTH'(TRAIL_DISTANCE);

  logic                    load_ok_s;
  logic                    rd_elig_s;
  logic                    grant_wr_s;
  logic                    grant_rd_s;
  logic [CREDIT_WIDTH-1:0] rd_thresh_s;
  logic                    last_rd_r;

  // Grant selection: single eligible side wins, otherwise alternate against the last grant.
  always_comb begin
    grant_wr_s  = 1'b0;
    grant_rd_s  = 1'b0;
    load_ok_s   = enable && (!out_cmd_valid || out_cmd_ready);
    rd_thresh_s = drain ? CREDIT_ONE : TRAIL_THRESH;
    rd_elig_s   = rd_cmd_valid && (credit_count >= rd_thresh_s);
    if (load_ok_s) begin
      case ({wr_cmd_valid, rd_elig_s})
        2'b10: grant_wr_s = 1'b1;
        2'b01: grant_rd_s = 1'b1;
        2'b11: begin
          grant_wr_s = last_rd_r;
          grant_rd_s = !last_rd_r;
        end
        default: begin
          grant_wr_s = 1'b0;
          grant_rd_s = 1'b0;
        end
      endcase
    end else begin
      grant_wr_s = 1'b0;
      grant_rd_s = 1'b0;
    end
  end

  assign wr_cmd_ready = grant_wr_s;
  assign rd_cmd_ready = grant_rd_s;

  // Output register, round-robin pointer and credit counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_cmd_valid   <= 1'b0;
      out_cmd_data    <= {RD_DATA_WIDTH{1'b0}};
      out_cmd_is_read <= 1'b0;
      credit_count    <= {CREDIT_WIDTH{1'b0}};
      credit_overflow <= 1'b0;
      // Pretend the last grant was a read so a write wins the first tie.
      last_rd_r       <= 1'b1;
    end else begin
      if (grant_wr_s) begin
        out_cmd_valid   <= 1'b1;
        out_cmd_data    <= RD_DATA_WIDTH'(wr_cmd_data);
        out_cmd_is_read <= 1'b0;
        last_rd_r       <= 1'b0;
      end else if (grant_rd_s) begin
        out_cmd_valid   <= 1'b1;
        out_cmd_data    <= rd_cmd_data;
        out_cmd_is_read <= 1'b1;
        last_rd_r       <= 1'b1;
      end else if (out_cmd_ready) begin
        out_cmd_valid   <= 1'b0;
      end

      // Simultaneous wr_done and read grant cancel out; a read grant implies credit >= 1.
      if (wr_done && !grant_rd_s) begin
        if (credit_count == CREDIT_MAX) begin
          credit_overflow <= 1'b1;
        end else begin
          credit_count <= credit_count + CREDIT_ONE;
        end
      end else if (!wr_done && grant_rd_s) begin
        credit_count <= credit_count - CREDIT_ONE;
      end
    end
  end

endmodule
